// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: glyph table, dp bit position
// and idle-level helpers for either pin polarity.
package seg_pkg;

   localparam int DP_BIT = 2;

   localparam logic [7:0] SEG_TABLE [16] = '{
      8'hFA, 8'h22, 8'hB9, 8'hAB, 8'h63, 8'hCB, 8'hDB, 8'hA2,
      8'hFB, 8'hEB, 8'hF3, 8'h5B, 8'hD8, 8'h3B, 8'hD9, 8'hD1
   };

   function automatic logic [7:0] seg_off(input logic active_low);
      return active_low ? 8'hFF : 8'h00;
   endfunction

   // Wide enough for the largest supported digit count; callers slice it.
   function automatic logic [15:0] dig_off(input logic active_low);
      return active_low ? 16'hFFFF : 16'h0000;
   endfunction

endpackage

// File: rtl/seg_encode.sv
// Nibble-to-glyph lookup with the decimal point merged in.
// Purely combinational, active-high pattern.
module seg_encode
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] pattern
);

   always_comb begin
      pattern         = SEG_TABLE[nibble];
      pattern[DP_BIT] = dp;
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver: double-buffered frame data, PWM brightness,
// leading-zero suppression; outputs registered one cycle behind the scan counters.
module seg_scan_driver #(
   parameter int DIGITS         = 4,
   parameter int DIV_LOG2       = 10,
   parameter int BRIGHT_W       = 4,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic                  lz_en,
   input  logic [BRIGHT_W-1:0]   bright,
   output logic [7:0]            seg,
   output logic [DIGITS-1:0]     dig,
   output logic                  frame_tick
);
   import seg_pkg::*;

   localparam int                IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
   localparam logic [7:0]        SEG_IDLE   = seg_off(SEG_ACTIVE_LOW != 0);
   localparam logic [15:0]       DIG_IDLE_W = dig_off(DIG_ACTIVE_LOW != 0);
   localparam logic [DIGITS-1:0] DIG_IDLE   = DIG_IDLE_W[DIGITS-1:0];

   logic [DIV_LOG2-1:0] div_cnt;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] pend_data, act_data;
   logic [DIGITS-1:0]   pend_dp, act_dp, pend_blank, act_blank;

   logic                wrap, frame_end, suppress, lit;
   logic                all_zero;
   logic [DIGITS-1:0]   zero_hi, dig_on;
   logic [3:0]          cur_nib;
   logic [7:0]          enc_seg, pat;

   seg_encode u_enc (
      .nibble  (cur_nib),
      .dp      (act_dp[idx]),
      .pattern (enc_seg)
   );

   // zero_hi[i]: every active nibble from i up to the top digit is zero.
   always_comb begin
      all_zero = 1'b1;
      zero_hi  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero   = all_zero & (act_data[4*i +: 4] == 4'h0);
         zero_hi[i] = all_zero;
      end
   end

   always_comb begin
      wrap      = &div_cnt;
      frame_end = wrap && (idx == IDX_LAST);
      cur_nib   = act_data[4*int'(idx) +: 4];
      suppress  = lz_en && (idx != '0) && zero_hi[idx];
      lit       = (div_cnt[DIV_LOG2-1 -: BRIGHT_W] < bright) && !act_blank[idx];
      dig_on    = DIGITS'(1) << idx;
      pat       = enc_seg;
      if (suppress) begin
         pat         = 8'h00;
         pat[DP_BIT] = act_dp[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt    <= '0;
         idx        <= '0;
         pend_data  <= '0;
         pend_dp    <= '0;
         pend_blank <= '1;
         act_data   <= '0;
         act_dp     <= '0;
         act_blank  <= '1;
         seg        <= SEG_IDLE;
         dig        <= DIG_IDLE;
         frame_tick <= 1'b0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         if (wrap)
            idx <= frame_end ? '0 : idx + 1'b1;

         if (load) begin
            pend_data  <= data;
            pend_dp    <= dp;
            pend_blank <= blank;
         end
         // A load coinciding with the boundary bypasses pending so it is not lost a frame.
         if (frame_end) begin
            act_data  <= load ? data  : pend_data;
            act_dp    <= load ? dp    : pend_dp;
            act_blank <= load ? blank : pend_blank;
         end

         frame_tick <= (div_cnt == '0) && (idx == '0);
         if (lit) begin
            seg <= (SEG_ACTIVE_LOW != 0) ? ~pat : pat;
            dig <= (DIG_ACTIVE_LOW != 0) ? ~dig_on : dig_on;
         end else begin
            seg <= SEG_IDLE;
            dig <= DIG_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with a 4-digit, 16-cycle-slot configuration.
module tb_seg_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n, load, lz_en;
   logic [15:0] data;
   logic [3:0]  dp, blank;
   logic [1:0]  bright;
   logic [7:0]  seg;
   logic [3:0]  dig;
   logic        frame_tick;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .DIGITS(4), .DIV_LOG2(4), .BRIGHT_W(2), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .data(data), .dp(dp), .blank(blank),
      .lz_en(lz_en), .bright(bright), .seg(seg), .dig(dig), .frame_tick(frame_tick)
   );

   localparam logic [7:0] TBL [16] = '{
      8'hFA, 8'h22, 8'hB9, 8'hAB, 8'h63, 8'hCB, 8'hDB, 8'hA2,
      8'hFB, 8'hEB, 8'hF3, 8'h5B, 8'hD8, 8'h3B, 8'hD9, 8'hD1
   };

   localparam int K_CLEAR = 0, K_SEG = 1, K_LIT = 2, K_FTCNT = 3, K_FTPER = 4,
                  K_SSEG = 5, K_SDIG = 6, K_SFT = 7;

   typedef struct {
      int kind;
      int d;
      int want;
   } chk_t;

   logic [12:0] exp_q [$];
   chk_t        ck_q  [$];
   string       nm_q  [$];

   int compared   = 0;
   int mismatched = 0;

   // monitor-owned observation records
   logic [7:0]  last_seg [4];
   int          lit_cnt  [4];
   int          ft_cnt, ft_per, last_ft, cyc;
   logic [7:0]  s_seg;
   logic [3:0]  s_dig;
   logic        s_ft;
   chk_t        c;
   string       nm;
   int          got;
   logic [12:0] e;

   initial begin
      ft_cnt = 0; ft_per = -1; last_ft = -1; cyc = 0;
      for (int d = 0; d < 4; d++) begin last_seg[d] = 8'h00; lit_cnt[d] = 0; end
   end

   always @(negedge clk) begin
      while (ck_q.size() > 0) begin
         c  = ck_q.pop_front();
         nm = nm_q.pop_front();
         if (c.kind == K_CLEAR) begin
            for (int d = 0; d < 4; d++) begin last_seg[d] = 8'h00; lit_cnt[d] = 0; end
            ft_cnt = 0;
         end else begin
            case (c.kind)
               K_SEG:   got = int'(last_seg[c.d]);
               K_LIT:   got = lit_cnt[c.d];
               K_FTCNT: got = ft_cnt;
               K_FTPER: got = ft_per;
               K_SSEG:  got = int'(s_seg);
               K_SDIG:  got = int'(s_dig);
               default: got = int'(s_ft);
            endcase
            compared++;
            if (got != c.want) begin
               mismatched++;
               $display("FAIL %s: got %0h, want %0h", nm, got, c.want);
            end
         end
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         compared++;
         if ({frame_tick, dig, seg} !== e) begin
            mismatched++;
            $display("FAIL scan cyc=%0d: got ft=%0b dig=%h seg=%h, want ft=%0b dig=%h seg=%h",
                     cyc, frame_tick, dig, seg, e[12], e[11:8], e[7:0]);
         end
         s_seg = seg; s_dig = dig; s_ft = frame_tick;
         if (frame_tick) begin
            ft_cnt++;
            if (last_ft >= 0) ft_per = cyc - last_ft;
            last_ft = cyc;
         end
         for (int d = 0; d < 4; d++)
            if (dig[d] == 1'b0) begin lit_cnt[d]++; last_seg[d] = seg; end
         cyc++;
      end
   end

   // reference scan state, advanced once per clock by step()
   int          m_div, m_idx;
   logic [15:0] m_pdata, m_adata;
   logic [3:0]  m_pdp, m_adp, m_pblank, m_ablank;

   task automatic step();
      logic [7:0] es;
      logic [3:0] ed;
      logic       ef, zh, sup, lt, bnd;
      logic [3:0] nib;
      if (!rst_n) begin
         es = 8'h00; ed = 4'hF; ef = 1'b0;
         m_div = 0; m_idx = 0;
         m_pdata = '0; m_adata = '0; m_pdp = '0; m_adp = '0;
         m_pblank = 4'hF; m_ablank = 4'hF;
      end else begin
         nib = m_adata[m_idx*4 +: 4];
         zh  = 1'b1;
         for (int j = m_idx; j < 4; j++)
            if (m_adata[j*4 +: 4] != 4'h0) zh = 1'b0;
         sup = lz_en && (m_idx != 0) && zh;
         lt  = ((m_div / 4) < int'(bright)) && !m_ablank[m_idx];
         es  = 8'h00;
         if (lt) begin
            es    = sup ? 8'h00 : TBL[nib];
            es[2] = m_adp[m_idx];
         end
         ed = lt ? ~(4'b0001 << m_idx) : 4'hF;
         ef = (m_div == 0) && (m_idx == 0);
         bnd = (m_div == 15) && (m_idx == 3);
         if (bnd) begin
            m_adata  = load ? data  : m_pdata;
            m_adp    = load ? dp    : m_pdp;
            m_ablank = load ? blank : m_pblank;
         end
         if (load) begin m_pdata = data; m_pdp = dp; m_pblank = blank; end
         m_div = (m_div + 1) % 16;
         if (m_div == 0) m_idx = (m_idx + 1) % 4;
      end
      @(posedge clk);
      exp_q.push_back({ef, ed, es});
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic to_frame();
      for (int k = 0; k < 200 && !(m_div == 0 && m_idx == 0); k++) step();
   endtask

   task automatic chk(input string name, input int kind, input int d, input int want);
      chk_t t;
      t.kind = kind; t.d = d; t.want = want;
      ck_q.push_back(t);
      nm_q.push_back(name);
   endtask

   task automatic clear();
      chk("clear", K_CLEAR, 0, 0);
   endtask

   // load a word, let it reach the display, then observe exactly one frame
   task automatic show(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
      data = d; dp = p; blank = b; load = 1'b1;
      step();
      load = 1'b0;
      to_frame();
      clear();
      run(64);
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; data = '0; dp = '0; blank = '0; lz_en = 1'b0; bright = 2'd3;
      run(3);
      chk("reset_seg", K_SSEG, 0, 'h00);
      chk("reset_dig", K_SDIG, 0, 'hF);
      chk("reset_ft",  K_SFT,  0, 0);
      rst_n = 1'b1;
      to_frame();
      clear();
      run(64);
      for (int d = 0; d < 4; d++) chk($sformatf("reset_blank_dig%0d", d), K_LIT, d, 0);

      // basic scan
      show(16'h12AF, 4'b0000, 4'b0000);
      chk("basic_seg0", K_SEG, 0, 'hD1);
      chk("basic_seg1", K_SEG, 1, 'hF3);
      chk("basic_seg2", K_SEG, 2, 'hB9);
      chk("basic_seg3", K_SEG, 3, 'h22);
      for (int d = 0; d < 4; d++) chk($sformatf("basic_lit%0d", d), K_LIT, d, 12);
      chk("basic_ftcnt", K_FTCNT, 0, 1);
      run(64);
      chk("ft_period", K_FTPER, 0, 64);

      // tear-free update issued during digit 1's slot
      run(20);
      clear();
      data = 16'h8888; load = 1'b1;
      step();
      load = 1'b0;
      to_frame();
      chk("tear_seg2", K_SEG, 2, 'hB9);
      chk("tear_seg3", K_SEG, 3, 'h22);
      clear();
      run(64);
      for (int d = 0; d < 4; d++) chk($sformatf("tear_new%0d", d), K_SEG, d, 'hFB);

      // decimal point and blank
      show(16'h8888, 4'b0100, 4'b1000);
      chk("dp_seg2",  K_SEG, 2, 'hFF);
      chk("dp_seg0",  K_SEG, 0, 'hFB);
      chk("dp_seg1",  K_SEG, 1, 'hFB);
      chk("blank_d3", K_LIT, 3, 0);

      // leading-zero suppression
      lz_en = 1'b1;
      show(16'h0050, 4'b0000, 4'b0000);
      chk("lz_seg0", K_SEG, 0, 'hFA);
      chk("lz_seg1", K_SEG, 1, 'hCB);
      chk("lz_seg2", K_SEG, 2, 'h00);
      chk("lz_seg3", K_SEG, 3, 'h00);
      show(16'h0000, 4'b0000, 4'b0000);
      chk("lz0_seg0", K_SEG, 0, 'hFA);
      chk("lz0_seg1", K_SEG, 1, 'h00);
      chk("lz0_seg3", K_SEG, 3, 'h00);
      show(16'h0000, 4'b0010, 4'b0000);
      chk("lzdp_seg1", K_SEG, 1, 'h04);
      chk("lzdp_seg0", K_SEG, 0, 'hFA);
      lz_en = 1'b0;

      // brightness
      bright = 2'd0;
      show(16'h1234, 4'b0000, 4'b0000);
      for (int d = 0; d < 4; d++) chk($sformatf("dark_lit%0d", d), K_LIT, d, 0);
      bright = 2'd1;
      clear();
      run(64);
      for (int d = 0; d < 4; d++) chk($sformatf("dim_lit%0d", d), K_LIT, d, 4);
      chk("dim_seg0", K_SEG, 0, 'h63);
      chk("dim_seg3", K_SEG, 3, 'h22);

      // reset in the lit part of digit 1's slot
      run(17);
      chk("pre_reset_dig", K_SDIG, 0, 'hD);
      rst_n = 1'b0;
      step();
      chk("midrst_seg", K_SSEG, 0, 'h00);
      chk("midrst_dig", K_SDIG, 0, 'hF);
      run(2);
      rst_n = 1'b1;
      step();
      chk("restart_ft", K_SFT, 0, 1);
      run(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
